// File: rtl/mem_pkg.sv
// Shared types and field positions for the MEM pipeline stage.
package mem_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } mem_state_e;

    localparam int unsigned WbW            = 12;
    localparam int unsigned WbRegWrite2Bit = 7;
    localparam int unsigned WbRegWrite1Bit = 3;
    localparam int unsigned CntW           = 8;

    // A squashed instruction keeps its fields but must not write the register file.
    function automatic logic [WbW-1:0] squash_wb(input logic [WbW-1:0] wb);
        logic [WbW-1:0] r;
        r                 = wb;
        r[WbRegWrite2Bit] = 1'b0;
        r[WbRegWrite1Bit] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts ACCESS cycles spent waiting for a memory ack and flags the last allowed one.
module mem_timeout_counter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls until ack or timeout.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              memRd_in,
    input  logic              memWt_in,
    input  logic [ADDR_W-1:0] memAddr_in,
    input  logic [7:0]        storeData_in,
    input  logic [ADDR_W-1:0] aluOut_in,
    input  logic [WbW-1:0]    wb_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [7:0]        dmem_wdata,
    input  logic              dmem_ack,
    input  logic [7:0]        dmem_rdata,
    output logic              mem_wb_valid,
    output logic [7:0]        mem_wb_loadData,
    output logic [ADDR_W-1:0] mem_wb_aluOut,
    output logic [WbW-1:0]    mem_wb_wb,
    output logic              mem_err
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rd_q, rd_d;
    logic              err_q, err_d;
    logic              wbv_q, wbv_d;
    logic [7:0]        wbload_q, wbload_d;
    logic [ADDR_W-1:0] wbalu_q, wbalu_d;
    logic [WbW-1:0]    wbwb_q, wbwb_d;

    logic mem_op;
    logic tc;
    logic cnt_clear;
    logic cnt_en;

    assign mem_op    = valid_in & (memRd_in | memWt_in);
    assign cnt_clear = (state_q == StIdle) & mem_op;
    assign cnt_en    = (state_q == StAccess) & ~dmem_ack;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (mem_op) state_d = StAccess;
            StAccess: if (dmem_ack || tc) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        dmem_req = 1'b0;
        unique case (state_q)
            StIdle:   stall = mem_op;
            StAccess: begin
                stall    = ~dmem_ack;
                dmem_req = 1'b1;
            end
            default:  stall = 1'b0;
        endcase
    end

    // MEM/WB reloads every cycle; the default is a bubble carrying the current inputs.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rd_d     = rd_q;
        err_d    = err_q;
        wbv_d    = 1'b0;
        wbload_d = 8'h00;
        wbalu_d  = aluOut_in;
        wbwb_d   = squash_wb(wb_in);
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    addr_d  = memAddr_in;
                    wdata_d = storeData_in;
                    we_d    = memWt_in;
                    rd_d    = memRd_in & ~memWt_in;
                    if (memRd_in && memWt_in) err_d = 1'b1;
                end else begin
                    wbv_d  = valid_in;
                    wbwb_d = wb_in;
                end
            end
            StAccess: begin
                if (dmem_ack) begin
                    wbv_d    = 1'b1;
                    wbwb_d   = wb_in;
                    wbload_d = rd_q ? dmem_rdata : 8'h00;
                end else if (tc) begin
                    wbv_d = 1'b1;
                    err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            wbv_q    <= 1'b0;
            wbload_q <= '0;
            wbalu_q  <= '0;
            wbwb_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            wbv_q    <= wbv_d;
            wbload_q <= wbload_d;
            wbalu_q  <= wbalu_d;
            wbwb_q   <= wbwb_d;
        end
    end

    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign mem_err         = err_q;
    assign mem_wb_valid    = wbv_q;
    assign mem_wb_loadData = wbload_q;
    assign mem_wb_aluOut   = wbalu_q;
    assign mem_wb_wb       = wbwb_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: ADDR_W, 32, width of memAddr_in, aluOut_in, dmem_addr and mem_wb_aluOut.
REQ-002 Parameter: TIMEOUT, 16, maximum cycles in ACCESS awaiting dmem_ack (legal range 2..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  EX/MEM holds a live instruction.
REQ-006 memRd_in  input  1  instruction is a load.
REQ-007 memWt_in  input  1  instruction is a store.
REQ-008 memAddr_in  input  ADDR_W  effective data address.
REQ-009 storeData_in  input  8  store byte (regrd2 value).
REQ-010 aluOut_in  input  ADDR_W  ALU result, passed through.
REQ-011 wb_in  input  12  {flags N,Z,C,V[11:8], regWrite2[7], rd2[6:4], regWrite1[3], rd1[2:0]}.
REQ-012 stall  output  1  holds EX/MEM and earlier stages when high.
REQ-013 dmem_req  output  1  data-memory request.
REQ-014 dmem_we  output  1  1 = write, 0 = read; valid while dmem_req.
REQ-015 dmem_addr  output  ADDR_W  captured address.
REQ-016 dmem_wdata  output  8  captured store byte.
REQ-017 dmem_ack  input  1  one-cycle completion strobe from memory.
REQ-018 dmem_rdata  input  8  read byte; valid with dmem_ack.
REQ-019 mem_wb_valid  output  1  MEM/WB holds a live instruction.
REQ-020 mem_wb_loadData  output  8  loaded byte; 0 for non-loads.
REQ-021 mem_wb_aluOut  output  ADDR_W  registered aluOut_in.
REQ-022 mem_wb_wb  output  12  registered wb_in; regWrite bits cleared when squashed.
REQ-023 mem_err  output  1  sticky timeout/illegal-op flag.

Function
REQ-024 FSM states IDLE and ACCESS; a memory op is valid_in & (memRd_in | memWt_in).
REQ-025 IDLE, no memory op: MEM/WB registers load inputs next edge, mem_wb_valid = valid_in, loadData = 0; latency 1 cycle.
REQ-026 IDLE, memory op: capture address, store byte, dmem_we = memWt_in, go to ACCESS; MEM/WB loads bubble (valid 0, regWrite bits 0).
REQ-027 memRd_in and memWt_in both high: perform write only, set mem_err.
REQ-028 stall = (IDLE & memory op) | (ACCESS & ~dmem_ack), combinational.
REQ-029 dmem_req = (state == ACCESS); address, data, we stable throughout ACCESS.
REQ-030 ACCESS & dmem_ack: MEM/WB loads inputs, loadData = dmem_rdata for reads (0 for writes), valid 1; return to IDLE.
REQ-031 Timeout counter clears on IDLE->ACCESS, increments each ACCESS cycle without ack.
REQ-032 Counter reaching TIMEOUT-1 without ack: return to IDLE, set mem_err, MEM/WB loads valid 1 with regWrite bits 0, loadData 0.
REQ-033 Ack on the timeout cycle: ack wins, no error.
REQ-034 dmem_ack in IDLE: ignored; no state or output change.
REQ-035 ACCESS holds MEM/WB as bubble each non-ack cycle.

Reset
REQ-036 reset low: immediately state IDLE, counter 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, all mem_wb_* 0, mem_err 0; stall then follows REQ-028.
REQ-037 Reset mid-ACCESS drops dmem_req asynchronously; a later stray ack is ignored.

Structure
REQ-038 Package mem_pkg: state encoding (IDLE, ACCESS), wb_in field bit positions.
REQ-039 One sub-module: mem_timeout_counter (clear, enable, terminal-count output).

Verification
REQ-040 ALU op, valid_in 1, aluOut 0x0000_00A5 -> next cycle mem_wb_valid 1, aluOut 0xA5, loadData 0, stall never high.
REQ-041 Load addr 0x100, ack after 3 ACCESS cycles, rdata 0x5C -> stall high 4 cycles, dmem_we 0, loadData 0x5C, valid 1.
REQ-042 Store 0x3F to 0x20, ack first ACCESS cycle -> dmem_we 1, wdata 0x3F, loadData 0, regWrite bits passed.
REQ-043 Load, no ack, TIMEOUT 16 -> dmem_req drops after 16 cycles, mem_err 1, mem_wb_wb[7] and [3] 0.
REQ-044 memRd_in and memWt_in both 1 -> write issued, mem_err 1; reset low mid-ACCESS -> dmem_req 0 same cycle.
